stack_sequencer: RTL

- Drives 6502 stack traffic for the CPU core: push/pull sequencing on page STACK_PAGE, bus strobes, and s_inc/s_dec requests to the Sregister.
- Takes a stack command from the decoder, then runs 1–3 bus cycles.
- Captures pulled bytes and PC.
- Never asserts a direct S write; TXS/TSX remain on the existing s_write path.

---
 rtl/stack_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/stack_sequencer.sv
// 6502 stack push/pull sequencer: runs 1-3 stack bus cycles per decoder command and
// requests S increments/decrements. Optional sticky wrap detection via STACK_WRAP_DETECT_EN.
module stack_sequencer #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd,
  input  logic [7:0]  push_byte,
  input  logic [15:0] push_pc,
  input  logic [7:0]  push_p,
  input  logic [7:0]  s_in,
  input  logic [7:0]  rd_data,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wd,
  output logic        mem_write,
  output logic        mem_read,
  output logic        s_inc,
  output logic        s_dec,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pull_byte,
`ifdef STACK_WRAP_DETECT_EN
  output logic [15:0] pull_pc,
  output logic        wrap_err
`else
  output logic [15:0] pull_pc
`endif
);

  localparam logic [2:0] CmdPushB   = 3'd1;
  localparam logic [2:0] CmdPullB   = 3'd2;
  localparam logic [2:0] CmdPushPc  = 3'd3;
  localparam logic [2:0] CmdPullPc  = 3'd4;
  localparam logic [2:0] CmdPullInt = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StPush0,
    StPush1,
    StPush2,
    StPull0,
    StPull1,
    StPull2,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [7:0]  byte_q, byte_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  p_q, p_d;
  logic [7:0]  pull_byte_q, pull_byte_d;
  logic [15:0] pull_pc_q, pull_pc_d;

  logic        push_op;
  logic        pull_op;
  logic [7:0]  wd;
  logic [7:0]  pull_lo;

  assign pull_lo = s_in + 8'h01;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    byte_d      = byte_q;
    pc_d        = pc_q;
    p_d         = p_q;
    pull_byte_d = pull_byte_q;
    pull_pc_d   = pull_pc_q;
    push_op     = 1'b0;
    pull_op     = 1'b0;
    wd          = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && (cmd != 3'd0) && (cmd != 3'd7)) begin
          cmd_d   = cmd;
          byte_d  = push_byte;
          pc_d    = push_pc;
          p_d     = push_p;
          // Odd command codes are the push family.
          state_d = cmd[0] ? StPush0 : StPull0;
        end
      end
      StPush0: begin
        push_op = 1'b1;
        if (cmd_q == CmdPushB) begin
          wd      = byte_q;
          state_d = StDone;
        end else begin
          wd      = pc_q[15:8];
          state_d = StPush1;
        end
      end
      StPush1: begin
        push_op = 1'b1;
        wd      = pc_q[7:0];
        state_d = (cmd_q == CmdPushPc) ? StDone : StPush2;
      end
      StPush2: begin
        push_op = 1'b1;
        wd      = p_q;
        state_d = StDone;
      end
      StPull0: begin
        pull_op = 1'b1;
        if (cmd_q == CmdPullPc) begin
          pull_pc_d[7:0] = rd_data;
          state_d        = StPull1;
        end else begin
          // PULL_B and PULL_INT both start with the byte that lands in pull_byte.
          pull_byte_d = rd_data;
          state_d     = (cmd_q == CmdPullB) ? StDone : StPull1;
        end
      end
      StPull1: begin
        pull_op = 1'b1;
        if (cmd_q == CmdPullInt) begin
          pull_pc_d[7:0] = rd_data;
          state_d        = StPull2;
        end else begin
          pull_pc_d[15:8] = rd_data;
          state_d         = StDone;
        end
      end
      StPull2: begin
        pull_op         = 1'b1;
        pull_pc_d[15:8] = rd_data;
        state_d         = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_q       <= 3'd0;
      byte_q      <= 8'h00;
      pc_q        <= 16'h0000;
      p_q         <= 8'h00;
      pull_byte_q <= 8'h00;
      pull_pc_q   <= 16'h0000;
    end else if (cpu_en) begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      byte_q      <= byte_d;
      pc_q        <= pc_d;
      p_q         <= p_d;
      pull_byte_q <= pull_byte_d;
      pull_pc_q   <= pull_pc_d;
    end
  end

  // Address and data hold through cpu_en stalls; only the strobes are qualified.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wd    = 8'h00;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (!reset) begin
      if (push_op) begin
        mem_addr  = {STACK_PAGE, s_in};
        mem_wd    = wd;
        mem_write = cpu_en;
      end else if (pull_op) begin
        mem_addr = {STACK_PAGE, pull_lo};
        mem_read = cpu_en;
      end
    end
  end

  assign s_dec     = mem_write;
  assign s_inc     = mem_read;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone) && cpu_en && !reset;
  assign pull_byte = pull_byte_q;
  assign pull_pc   = pull_pc_q;

`ifdef STACK_WRAP_DETECT_EN
  logic wrap_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_err_q <= 1'b0;
    end else if ((mem_write && (s_in == 8'h00)) || (mem_read && (s_in == 8'hFF))) begin
      wrap_err_q <= 1'b1;
    end
  end

  assign wrap_err = wrap_err_q;
`endif

endmodule
